// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - machine-wide issue width and register address types
package common_pkg;

  localparam int MACHINE_WIDTH = 2;
  localparam int AREG_W        = 5;
  localparam int PREG_W        = 6;

  typedef logic [AREG_W-1:0] areg_addr_t;
  typedef logic [PREG_W-1:0] preg_addr_t;

endpackage

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - reorder buffer sizing, slot address/count types and entry payload
package rob_pkg;

  import common_pkg::*;

  localparam int ROB_DEPTH = 16;
  localparam int FU_NUM    = 4;
  localparam int ROB_AW    = $clog2(ROB_DEPTH);

  typedef logic [ROB_AW-1:0] rob_addr_t;
  typedef logic [ROB_AW:0]   rob_count_t;

  typedef struct packed {
    areg_addr_t areg;
    preg_addr_t preg;
  } rob_entry_t;

  // Slot arithmetic relies on ROB_DEPTH being a power of two: the add wraps for free.
  function automatic rob_addr_t rob_offset(input rob_addr_t base, input int unsigned off);
    return base + rob_addr_t'(off);
  endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// rtl/rob_ctrl_if.sv - allocate/complete/commit/status bundle between pipeline and reorder buffer
interface rob_ctrl_if
  import common_pkg::areg_addr_t, common_pkg::preg_addr_t;
  import rob_pkg::rob_addr_t, rob_pkg::rob_count_t;
#(
  parameter int MACHINE_WIDTH = common_pkg::MACHINE_WIDTH,
  parameter int FU_NUM        = rob_pkg::FU_NUM
);

  logic       [MACHINE_WIDTH-1:0] alloc_valid;
  areg_addr_t [MACHINE_WIDTH-1:0] alloc_areg;
  preg_addr_t [MACHINE_WIDTH-1:0] alloc_preg;
  logic                           alloc_ready;
  rob_addr_t  [MACHINE_WIDTH-1:0] alloc_addr;

  logic       [FU_NUM-1:0]        complete_valid;
  rob_addr_t  [FU_NUM-1:0]        complete_addr;

  logic       [MACHINE_WIDTH-1:0] commit_valid;
  areg_addr_t [MACHINE_WIDTH-1:0] commit_areg;
  preg_addr_t [MACHINE_WIDTH-1:0] commit_preg;

  logic                           flush;
  rob_count_t                     count;
  logic                           empty;

  modport master (
    output alloc_valid, alloc_areg, alloc_preg, complete_valid, complete_addr, flush,
    input  alloc_ready, alloc_addr, commit_valid, commit_areg, commit_preg, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_areg, alloc_preg, complete_valid, complete_addr, flush,
    output alloc_ready, alloc_addr, commit_valid, commit_areg, commit_preg, count, empty
  );

endinterface

// File: rtl/rob_payload_ram.sv
// rtl/rob_payload_ram.sv - per-slot areg/preg storage, one write and one async read port per lane
module rob_payload_ram
  import rob_pkg::rob_addr_t, rob_pkg::rob_entry_t;
#(
  parameter int MACHINE_WIDTH = common_pkg::MACHINE_WIDTH,
  parameter int ROB_DEPTH     = rob_pkg::ROB_DEPTH
) (
  input  logic                           clk,
  input  logic       [MACHINE_WIDTH-1:0] we,
  input  rob_addr_t  [MACHINE_WIDTH-1:0] waddr,
  input  rob_entry_t [MACHINE_WIDTH-1:0] wdata,
  input  rob_addr_t  [MACHINE_WIDTH-1:0] raddr,
  output rob_entry_t [MACHINE_WIDTH-1:0] rdata
);

  rob_entry_t mem [ROB_DEPTH];

  // Write lanes always target distinct consecutive slots, so lane order never matters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      if (we[i]) begin
        mem[waddr[i]] <= wdata[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      rdata[i] = mem[raddr[i]];
    end
  end

endmodule

// File: rtl/rob_ctrl.sv
// rtl/rob_ctrl.sv - circular reorder buffer: in-order multi-lane allocate/commit, out-of-order completion
module rob_ctrl
  import rob_pkg::rob_addr_t, rob_pkg::rob_count_t, rob_pkg::rob_entry_t, rob_pkg::rob_offset;
#(
  parameter int MACHINE_WIDTH = common_pkg::MACHINE_WIDTH,
  parameter int ROB_DEPTH     = rob_pkg::ROB_DEPTH,
  parameter int FU_NUM        = rob_pkg::FU_NUM
) (
  input logic     clk,
  input logic     reset,
  rob_ctrl_if.slave rob
);

  rob_addr_t              head;
  rob_addr_t              tail;
  rob_count_t             count_q;
  logic [ROB_DEPTH-1:0]   valid_q;
  logic [ROB_DEPTH-1:0]   done_q;

  logic                           ready;
  logic                           chain;
  logic       [MACHINE_WIDTH-1:0] alloc_we;
  logic       [MACHINE_WIDTH-1:0] commit_v;
  rob_addr_t  [MACHINE_WIDTH-1:0] alloc_slot;
  rob_addr_t  [MACHINE_WIDTH-1:0] commit_slot;
  rob_entry_t [MACHINE_WIDTH-1:0] alloc_data;
  rob_entry_t [MACHINE_WIDTH-1:0] commit_data;
  rob_count_t                     alloc_n;
  rob_count_t                     commit_n;

  // Depends only on the occupancy register, so upstream may gate alloc_valid on it freely.
  assign ready = (ROB_DEPTH - int'(count_q)) >= MACHINE_WIDTH;

  always_comb begin
    alloc_n  = '0;
    commit_n = '0;
    chain    = !rob.flush;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      alloc_slot[i]  = rob_offset(tail, i);
      commit_slot[i] = rob_offset(head, i);
      alloc_data[i]  = '{areg: rob.alloc_areg[i], preg: rob.alloc_preg[i]};
      alloc_we[i]    = ready && !rob.flush && rob.alloc_valid[i];
      if (alloc_we[i]) begin
        alloc_n = alloc_n + rob_count_t'(1);
      end
      // A lane retires only if every older lane retires too.
      chain       = chain && valid_q[commit_slot[i]] && done_q[commit_slot[i]];
      commit_v[i] = chain;
      if (chain) begin
        commit_n = commit_n + rob_count_t'(1);
      end
    end
  end

  rob_payload_ram #(
    .MACHINE_WIDTH (MACHINE_WIDTH),
    .ROB_DEPTH     (ROB_DEPTH)
  ) u_payload (
    .clk   (clk),
    .we    (alloc_we),
    .waddr (alloc_slot),
    .wdata (alloc_data),
    .raddr (commit_slot),
    .rdata (commit_data)
  );

  assign rob.alloc_ready  = ready;
  assign rob.alloc_addr   = alloc_slot;
  assign rob.commit_valid = commit_v;
  assign rob.count        = count_q;
  assign rob.empty        = (count_q == '0);

  for (genvar g = 0; g < MACHINE_WIDTH; g++) begin : g_commit
    assign rob.commit_areg[g] = commit_data[g].areg;
    assign rob.commit_preg[g] = commit_data[g].preg;
  end

  always_ff @(posedge clk) begin
    if (reset || rob.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      for (int f = 0; f < FU_NUM; f++) begin
        if (rob.complete_valid[f] && valid_q[rob.complete_addr[f]]) begin
          done_q[rob.complete_addr[f]] <= 1'b1;
        end
      end
      // Retiring slots are cleared after completion so a late writeback cannot revive them.
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (commit_v[i]) begin
          valid_q[commit_slot[i]] <= 1'b0;
          done_q[commit_slot[i]]  <= 1'b0;
        end
      end
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (alloc_we[i]) begin
          valid_q[alloc_slot[i]] <= 1'b1;
          done_q[alloc_slot[i]]  <= 1'b0;
        end
      end
      head    <= head + rob_addr_t'(commit_n);
      tail    <= tail + rob_addr_t'(alloc_n);
      count_q <= count_q + alloc_n - commit_n;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// tb/tb_rob_ctrl.sv - scoreboard bench for rob_ctrl against a queue-based reorder buffer model
module tb_rob_ctrl;
  import common_pkg::areg_addr_t, common_pkg::preg_addr_t;
  import rob_pkg::rob_addr_t;

  localparam int MW    = 2;
  localparam int DEPTH = 16;
  localparam int FU    = 4;

  typedef struct { int slot; int areg; int preg; bit done; } ent_t;
  typedef struct { int areg; int preg; } pay_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rob_ctrl_if #(.MACHINE_WIDTH(MW), .FU_NUM(FU)) bus ();

  rob_ctrl #(
    .MACHINE_WIDTH (MW),
    .ROB_DEPTH     (DEPTH),
    .FU_NUM        (FU)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  ent_t mq[$];
  pay_t exp_q[$];
  int   m_tail = 0;

  int s_av;
  int s_areg [MW];
  int s_preg [MW];
  bit s_cv   [FU];
  int s_ca   [FU];
  bit s_flush;
  bit s_reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    s_av = 0;
    s_flush = 1'b0;
    s_reset = 1'b0;
    for (int f = 0; f < FU; f++) begin
      s_cv[f] = 1'b0;
      s_ca[f] = 0;
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < MW; i++) begin
      s_areg[i] = int'($urandom_range(31));
      s_preg[i] = int'($urandom_range(63));
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    int ncommit;
    bit ready;
    @(negedge clk);
    reset    = s_reset;
    bus.flush = s_flush;
    for (int i = 0; i < MW; i++) begin
      bus.alloc_valid[i] = (i < s_av);
      bus.alloc_areg[i]  = areg_addr_t'(s_areg[i]);
      bus.alloc_preg[i]  = preg_addr_t'(s_preg[i]);
    end
    for (int f = 0; f < FU; f++) begin
      bus.complete_valid[f] = s_cv[f];
      bus.complete_addr[f]  = rob_addr_t'(s_ca[f]);
    end
    #1;
    ncommit = 0;
    if (!s_flush) begin
      while (ncommit < MW && ncommit < mq.size() && mq[ncommit].done) ncommit++;
    end
    ready = (DEPTH - mq.size()) >= MW;
    check("count", 32'(bus.count), mq.size());
    check("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check("alloc_ready", 32'(bus.alloc_ready), 32'(ready));
    for (int i = 0; i < MW; i++) begin
      check("alloc_addr", 32'(bus.alloc_addr[i]), (m_tail + i) % DEPTH);
    end
    check("commit_valid", 32'(bus.commit_valid), (1 << ncommit) - 1);
    #2;
    if (s_reset || s_flush) begin
      mq.delete();
      exp_q.delete();
      m_tail = 0;
    end else begin
      repeat (ncommit) mq.delete(0);
      for (int f = 0; f < FU; f++) begin
        if (s_cv[f]) begin
          foreach (mq[k]) if (mq[k].slot == s_ca[f]) mq[k].done = 1'b1;
        end
      end
      if (ready) begin
        for (int i = 0; i < s_av; i++) begin
          mq.push_back('{m_tail, s_areg[i], s_preg[i], 1'b0});
          exp_q.push_back('{s_areg[i], s_preg[i]});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  // Retirement monitor: every asserted commit lane must match the oldest allocation outstanding.
  initial begin
    pay_t p;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < MW; i++) begin
        if (bus.commit_valid[i] === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL commit_extra: lane %0d retired with nothing outstanding", i);
          end else begin
            p = exp_q.pop_front();
            check("commit_areg", 32'(bus.commit_areg[i]), p.areg);
            check("commit_preg", 32'(bus.commit_preg[i]), p.preg);
          end
        end
      end
    end
  end

  initial begin
    bus.alloc_valid    = '0;
    bus.alloc_areg     = '0;
    bus.alloc_preg     = '0;
    bus.complete_valid = '0;
    bus.complete_addr  = '0;
    bus.flush          = 1'b0;
    idle();
    rand_payload();

    s_reset = 1'b1; cycle(); cycle(); idle();
    settle();
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_ready", 32'(bus.alloc_ready), 1);
    check("rst_commit_valid", 32'(bus.commit_valid), 0);
    check("rst_addr0", 32'(bus.alloc_addr[0]), 0);
    check("rst_addr1", 32'(bus.alloc_addr[1]), 1);

    repeat (8) begin s_av = 2; rand_payload(); cycle(); end
    idle(); settle();
    check("fill_count", 32'(bus.count), 16);
    check("fill_ready", 32'(bus.alloc_ready), 0);
    s_av = 2; rand_payload(); cycle(); idle(); settle();
    check("full_count", 32'(bus.count), 16);
    check("full_tail", 32'(bus.alloc_addr[0]), 0);

    s_reset = 1'b1; cycle(); idle();
    s_av = 2; s_areg[0] = 3; s_areg[1] = 7; s_preg[0] = 40; s_preg[1] = 41; cycle(); idle();
    s_cv[0] = 1'b1; s_ca[0] = 1; cycle(); idle(); settle();
    check("ooo_no_commit", 32'(bus.commit_valid), 0);
    s_cv[0] = 1'b1; s_ca[0] = 0; cycle(); idle(); settle();
    check("ooo_commit", 32'(bus.commit_valid), 3);
    check("ooo_areg0", 32'(bus.commit_areg[0]), 3);
    check("ooo_areg1", 32'(bus.commit_areg[1]), 7);
    check("ooo_preg1", 32'(bus.commit_preg[1]), 41);
    cycle();

    s_reset = 1'b1; cycle(); idle();
    for (int k = 0; k < 16; k++) begin
      rand_payload();
      s_av = (k < 15) ? 1 : 0;
      s_cv[0] = (k > 0);
      s_ca[0] = (k > 0) ? k - 1 : 0;
      cycle(); idle();
    end
    cycle(); cycle(); settle();
    check("wrap_count", 32'(bus.count), 0);
    check("wrap_addr0", 32'(bus.alloc_addr[0]), 15);
    check("wrap_addr1", 32'(bus.alloc_addr[1]), 0);
    s_av = 2; rand_payload(); cycle(); idle();
    s_cv[0] = 1'b1; s_ca[0] = 15; s_cv[1] = 1'b1; s_ca[1] = 0; cycle(); idle(); settle();
    check("wrap_commit", 32'(bus.commit_valid), 3);
    cycle(); settle();
    check("wrap_head", 32'(bus.alloc_addr[0]), 1);
    check("wrap_empty", 32'(bus.empty), 1);

    s_reset = 1'b1; cycle(); idle();
    repeat (7) begin s_av = 2; rand_payload(); cycle(); end
    idle();
    s_cv[0] = 1'b1; s_ca[0] = 0; s_cv[1] = 1'b1; s_ca[1] = 1; cycle(); idle();
    s_av = 2; rand_payload(); cycle(); idle(); settle();
    check("simul_count", 32'(bus.count), 14);
    check("simul_tail", 32'(bus.alloc_addr[0]), 0);

    s_reset = 1'b1; cycle(); idle();
    repeat (3) begin s_av = 2; rand_payload(); cycle(); end
    idle();
    s_cv[0] = 1'b1; s_ca[0] = 0; cycle(); idle();
    s_flush = 1'b1; s_av = 2; rand_payload(); s_cv[0] = 1'b1; s_ca[0] = 1; cycle(); idle(); settle();
    check("flush_count", 32'(bus.count), 0);
    check("flush_empty", 32'(bus.empty), 1);
    check("flush_tail", 32'(bus.alloc_addr[0]), 0);
    check("flush_commit", 32'(bus.commit_valid), 0);

    repeat (400) begin
      s_av = int'($urandom_range(2));
      rand_payload();
      for (int f = 0; f < FU; f++) begin
        s_cv[f] = 1'($urandom_range(1));
        if (mq.size() > 0 && $urandom_range(3) != 0)
          s_ca[f] = mq[$urandom_range(mq.size() - 1)].slot;
        else
          s_ca[f] = int'($urandom_range(DEPTH - 1));
      end
      s_flush = ($urandom_range(39) == 0);
      s_reset = ($urandom_range(99) == 0);
      cycle();
    end
    idle();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
